gray_to_rgb_serializer: RTL and testbench

GRAY_TO_RGB_SERIALIZER -- requirements
Module: gray_to_rgb_serializer

---
 rtl/gray_to_rgb_serializer_if.sv | 26 ++
 rtl/gray_to_rgb_serializer.sv | 150 +++++++++++++++
 tb/tb_gray_to_rgb_serializer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_to_rgb_serializer_if.sv
// Pixel-in / byte-out handshake bundle for the grayscale-to-RGB serializer.
// The slave modport is the serializer's view; the master modport is the driving side.
interface gray_to_rgb_serializer_if #(
  parameter int P_SUBPIXEL_DEPTH = 8
);
  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL;
  logic                        I_PIXEL_VALID;
  logic                        I_FRAME_START;
  logic                        O_PIXEL_READY;
  logic [P_SUBPIXEL_DEPTH-1:0] O_BYTE;
  logic [1:0]                  O_BYTE_CHANNEL;
  logic                        O_BYTE_VALID;
  logic                        I_BYTE_READY;
  logic                        O_FRAME_START;
  logic [15:0]                 O_PIXEL_COUNT;

  modport slave (
    input  I_PIXEL, I_PIXEL_VALID, I_FRAME_START, I_BYTE_READY,
    output O_PIXEL_READY, O_BYTE, O_BYTE_CHANNEL, O_BYTE_VALID, O_FRAME_START, O_PIXEL_COUNT
  );

  modport master (
    output I_PIXEL, I_PIXEL_VALID, I_FRAME_START, I_BYTE_READY,
    input  O_PIXEL_READY, O_BYTE, O_BYTE_CHANNEL, O_BYTE_VALID, O_FRAME_START, O_PIXEL_COUNT
  );
endinterface

// File: rtl/gray_to_rgb_serializer.sv
// Expands each grayscale pixel into three identical channel bytes (R,G,B or B,G,R),
// with a one-entry skid buffer so a following pixel can stream in with no idle beat.
module gray_to_rgb_serializer #(
  parameter int P_SUBPIXEL_DEPTH = 8,
  parameter bit P_ORDER_BGR      = 1'b0
) (
  input logic                     I_CLK,
  input logic                     I_RESET,
  gray_to_rgb_serializer_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND_0 = 2'd1;
  localparam logic [1:0] ST_SEND_1 = 2'd2;
  localparam logic [1:0] ST_SEND_2 = 2'd3;

  function automatic logic [1:0] channel_of(input logic [1:0] st);
    case (st)
      ST_SEND_0: channel_of = P_ORDER_BGR ? 2'd2 : 2'd0;
      ST_SEND_1: channel_of = 2'd1;
      ST_SEND_2: channel_of = P_ORDER_BGR ? 2'd0 : 2'd2;
      default:   channel_of = 2'd0;
    endcase
  endfunction

  logic [1:0]                  state_r;
  logic [P_SUBPIXEL_DEPTH-1:0] cur_pix_r;
  logic                        cur_fs_r;
  logic [P_SUBPIXEL_DEPTH-1:0] skid_pix_r;
  logic                        skid_fs_r;
  logic                        skid_full_r;
  logic [15:0]                 count_r;
  logic                        byte_valid_r;
  logic [1:0]                  byte_channel_r;
  logic                        frame_start_r;

  logic                        ready_s;
  logic                        accept_s;
  logic                        beat_s;
  logic [1:0]                  state_nxt_s;
  logic [P_SUBPIXEL_DEPTH-1:0] cur_pix_nxt_s;
  logic                        cur_fs_nxt_s;
  logic [P_SUBPIXEL_DEPTH-1:0] skid_pix_nxt_s;
  logic                        skid_fs_nxt_s;
  logic                        skid_full_nxt_s;
  logic [15:0]                 count_nxt_s;

  assign ready_s  = ~skid_full_r & ~I_RESET;
  assign accept_s = bus.I_PIXEL_VALID & ready_s;
  assign beat_s   = byte_valid_r & bus.I_BYTE_READY;

  // Next-state, storage and counter decode for one pixel beat sequence.
  always_comb begin
    state_nxt_s     = state_r;
    cur_pix_nxt_s   = cur_pix_r;
    cur_fs_nxt_s    = cur_fs_r;
    skid_pix_nxt_s  = skid_pix_r;
    skid_fs_nxt_s   = skid_fs_r;
    skid_full_nxt_s = skid_full_r;
    count_nxt_s     = count_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cur_pix_nxt_s = bus.I_PIXEL;
          cur_fs_nxt_s  = bus.I_FRAME_START;
          state_nxt_s   = ST_SEND_0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_SEND_0, ST_SEND_1: begin
        if (beat_s) begin
          state_nxt_s = (state_r == ST_SEND_0) ? ST_SEND_1 : ST_SEND_2;
        end else begin
          state_nxt_s = state_r;
        end
        if (accept_s) begin
          skid_pix_nxt_s  = bus.I_PIXEL;
          skid_fs_nxt_s   = bus.I_FRAME_START;
          skid_full_nxt_s = 1'b1;
        end else begin
          skid_full_nxt_s = skid_full_r;
        end
      end
      ST_SEND_2: begin
        if (beat_s) begin
          // A frame-start pixel restarts the count at itself.
          count_nxt_s = cur_fs_r ? 16'd1 : (count_r + 16'd1);
          if (skid_full_r) begin
            cur_pix_nxt_s   = skid_pix_r;
            cur_fs_nxt_s    = skid_fs_r;
            skid_full_nxt_s = 1'b0;
            skid_fs_nxt_s   = 1'b0;
            state_nxt_s     = ST_SEND_0;
          end else if (accept_s) begin
            cur_pix_nxt_s   = bus.I_PIXEL;
            cur_fs_nxt_s    = bus.I_FRAME_START;
            state_nxt_s     = ST_SEND_0;
          end else begin
            state_nxt_s     = ST_IDLE;
          end
        end else if (accept_s) begin
          skid_pix_nxt_s  = bus.I_PIXEL;
          skid_fs_nxt_s   = bus.I_FRAME_START;
          skid_full_nxt_s = 1'b1;
        end else begin
          state_nxt_s     = ST_SEND_2;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, storage and registered output update; reset wins over any handshake.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_r        <= ST_IDLE;
      cur_pix_r      <= {P_SUBPIXEL_DEPTH{1'b0}};
      cur_fs_r       <= 1'b0;
      skid_pix_r     <= {P_SUBPIXEL_DEPTH{1'b0}};
      skid_fs_r      <= 1'b0;
      skid_full_r    <= 1'b0;
      count_r        <= 16'd0;
      byte_valid_r   <= 1'b0;
      byte_channel_r <= 2'd0;
      frame_start_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cur_pix_r      <= cur_pix_nxt_s;
      cur_fs_r       <= cur_fs_nxt_s;
      skid_pix_r     <= skid_pix_nxt_s;
      skid_fs_r      <= skid_fs_nxt_s;
      skid_full_r    <= skid_full_nxt_s;
      count_r        <= count_nxt_s;
      byte_valid_r   <= (state_nxt_s != ST_IDLE);
      byte_channel_r <= channel_of(state_nxt_s);
      frame_start_r  <= (state_nxt_s == ST_SEND_0) & cur_fs_nxt_s;
    end
  end

  assign bus.O_PIXEL_READY  = ready_s;
  assign bus.O_BYTE         = cur_pix_r;
  assign bus.O_BYTE_CHANNEL = byte_channel_r;
  assign bus.O_BYTE_VALID   = byte_valid_r;
  assign bus.O_FRAME_START  = frame_start_r;
  assign bus.O_PIXEL_COUNT  = count_r;

endmodule

// File: tb/tb_gray_to_rgb_serializer.sv
// Scoreboard bench: RGB-order and BGR-order instances share stimulus; each has its own
// expected-beat queue drained by an independent monitor.
module tb_gray_to_rgb_serializer;

  typedef struct packed {
    logic [7:0]  b;
    logic [1:0]  ch;
    logic        fs;
    logic        last;
    logic [15:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] pix;
  logic       pvalid;
  logic       fsi;
  logic       byte_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [15:0] model_cnt;

  gray_to_rgb_serializer_if #(.P_SUBPIXEL_DEPTH(8)) bus_a ();
  gray_to_rgb_serializer_if #(.P_SUBPIXEL_DEPTH(8)) bus_b ();

  assign bus_a.I_PIXEL       = pix;
  assign bus_a.I_PIXEL_VALID = pvalid;
  assign bus_a.I_FRAME_START = fsi;
  assign bus_a.I_BYTE_READY  = byte_ready;
  assign bus_b.I_PIXEL       = pix;
  assign bus_b.I_PIXEL_VALID = pvalid;
  assign bus_b.I_FRAME_START = fsi;
  assign bus_b.I_BYTE_READY  = byte_ready;

  gray_to_rgb_serializer #(.P_SUBPIXEL_DEPTH(8), .P_ORDER_BGR(1'b0)) dut_a (
    .I_CLK(clk), .I_RESET(rst), .bus(bus_a)
  );
  gray_to_rgb_serializer #(.P_SUBPIXEL_DEPTH(8), .P_ORDER_BGR(1'b1)) dut_b (
    .I_CLK(clk), .I_RESET(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_pixel(input logic [7:0] p, input logic f);
    exp_t e;
    model_cnt = f ? 16'd1 : model_cnt + 16'd1;
    for (int i = 0; i < 3; i++) begin
      e.b = p; e.fs = f && (i == 0); e.last = (i == 2); e.cnt = model_cnt;
      e.ch = 2'(i);
      q_a.push_back(e);
      e.ch = 2'(2 - i);
      q_b.push_back(e);
    end
  endfunction

  // Monitor for the R,G,B instance.
  logic        chk_a = 1'b0;
  logic [15:0] cnt_exp_a;
  always @(negedge clk) begin
    exp_t e;
    if (chk_a) begin
      check("a_count", 32'(bus_a.O_PIXEL_COUNT), 32'(cnt_exp_a));
      chk_a = 1'b0;
    end
    if (bus_a.O_BYTE_VALID && byte_ready) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_beat", 32'(bus_a.O_BYTE), 32'hDEAD);
      end else begin
        e = q_a.pop_front();
        check("a_byte", 32'(bus_a.O_BYTE), 32'(e.b));
        check("a_chan", 32'(bus_a.O_BYTE_CHANNEL), 32'(e.ch));
        check("a_fstart", 32'(bus_a.O_FRAME_START), 32'(e.fs));
        if (e.last) begin chk_a = 1'b1; cnt_exp_a = e.cnt; end
      end
    end
  end

  // Monitor for the B,G,R instance.
  logic        chk_b = 1'b0;
  logic [15:0] cnt_exp_b;
  always @(negedge clk) begin
    exp_t e;
    if (chk_b) begin
      check("b_count", 32'(bus_b.O_PIXEL_COUNT), 32'(cnt_exp_b));
      chk_b = 1'b0;
    end
    if (bus_b.O_BYTE_VALID && byte_ready) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_beat", 32'(bus_b.O_BYTE), 32'hDEAD);
      end else begin
        e = q_b.pop_front();
        check("b_byte", 32'(bus_b.O_BYTE), 32'(e.b));
        check("b_chan", 32'(bus_b.O_BYTE_CHANNEL), 32'(e.ch));
        check("b_fstart", 32'(bus_b.O_FRAME_START), 32'(e.fs));
        if (e.last) begin chk_b = 1'b1; cnt_exp_b = e.cnt; end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pixel(input logic [7:0] p, input logic f);
    int n = 0;
    pix = p; fsi = f; pvalid = 1'b1;
    @(negedge clk);
    while (!bus_a.O_PIXEL_READY && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus_a.O_PIXEL_READY) begin
      check("accept_timeout", 32'(bus_a.O_PIXEL_READY), 32'd1);
      @(posedge clk); #1;
      pvalid = 1'b0;
    end else begin
      push_pixel(p, f);
      @(posedge clk); #1;
      pvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || bus_a.O_BYTE_VALID) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(q_a.size()), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int run, max_run, n_valid;
  logic saw_not_ready;

  initial begin
    rst = 1'b1; pvalid = 1'b0; pix = 8'h00; fsi = 1'b0; byte_ready = 1'b1;
    model_cnt = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus_a.O_PIXEL_READY), 32'd0);
    check("rst_valid", 32'(bus_a.O_BYTE_VALID), 32'd0);
    check("rst_byte", 32'(bus_a.O_BYTE), 32'd0);
    check("rst_chan", 32'(bus_a.O_BYTE_CHANNEL), 32'd0);
    check("rst_fstart", 32'(bus_a.O_FRAME_START), 32'd0);
    check("rst_count", 32'(bus_a.O_PIXEL_COUNT), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus_a.O_PIXEL_READY), 32'd1);
    @(posedge clk); #1;

    // Single frame-start pixel: first beat one cycle after accept.
    send_pixel(8'h5A, 1'b1);
    @(negedge clk);
    check("lat1_valid", 32'(bus_a.O_BYTE_VALID), 32'd1);
    check("lat1_fstart", 32'(bus_a.O_FRAME_START), 32'd1);
    check("lat1_byte", 32'(bus_a.O_BYTE), 32'h5A);
    @(posedge clk); #1;
    wait_idle();
    check("single_idle", 32'(bus_a.O_BYTE_VALID), 32'd0);
    check("single_count", 32'(bus_a.O_PIXEL_COUNT), 32'd1);

    // Back-to-back stream: nine gapless beats, ready drops while skid full.
    run = 0; max_run = 0; n_valid = 0; saw_not_ready = 1'b0;
    fork
      begin
        send_pixel(8'h10, 1'b0);
        send_pixel(8'h20, 1'b0);
        send_pixel(8'h30, 1'b0);
      end
      begin
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (bus_a.O_BYTE_VALID) begin
            run++; n_valid++;
            if (run > max_run) max_run = run;
          end else begin
            run = 0;
          end
          if (!bus_a.O_PIXEL_READY) saw_not_ready = 1'b1;
        end
      end
    join
    wait_idle();
    check("b2b_beats", 32'(n_valid), 32'd9);
    check("b2b_gapless", 32'(max_run), 32'd9);
    check("b2b_ready_drop", 32'(saw_not_ready), 32'd1);
    check("b2b_count", 32'(bus_a.O_PIXEL_COUNT), 32'd4);

    // Backpressure in SEND_1 with a second pixel parked in the skid buffer.
    send_pixel(8'h77, 1'b1);
    @(posedge clk); #1;
    byte_ready = 1'b0;
    send_pixel(8'h88, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_byte", 32'(bus_a.O_BYTE), 32'h77);
      check("bp_chan", 32'(bus_a.O_BYTE_CHANNEL), 32'd1);
      check("bp_valid", 32'(bus_a.O_BYTE_VALID), 32'd1);
      check("bp_ready", 32'(bus_a.O_PIXEL_READY), 32'd0);
    end
    @(posedge clk); #1;
    byte_ready = 1'b1;
    wait_idle();
    check("bp_count", 32'(bus_a.O_PIXEL_COUNT), 32'd2);

    // White pixel: BGR instance must walk channels 2,1,0.
    send_pixel(8'hFF, 1'b1);
    wait_idle();
    check("bgr_count", 32'(bus_b.O_PIXEL_COUNT), 32'd1);

    // Input wiggles without valid must not produce beats.
    for (int k = 0; k < 5; k++) begin
      pix = 8'(k * 37); fsi = k[0];
      @(posedge clk); #1;
    end
    fsi = 1'b0;
    @(negedge clk);
    check("noaccept_valid", 32'(bus_a.O_BYTE_VALID), 32'd0);
    check("noaccept_count", 32'(bus_a.O_PIXEL_COUNT), 32'd1);
    @(posedge clk); #1;

    // Counter wrap: preload near the top, then complete three pixels.
    @(negedge clk);
    force dut_a.count_r = 16'hFFFE;
    force dut_b.count_r = 16'hFFFE;
    @(posedge clk); #1;
    release dut_a.count_r;
    release dut_b.count_r;
    model_cnt = 16'hFFFE;
    @(negedge clk);
    check("wrap_preload", 32'(bus_a.O_PIXEL_COUNT), 32'hFFFE);
    @(posedge clk); #1;
    send_pixel(8'h01, 1'b0);
    send_pixel(8'h02, 1'b0);
    wait_idle();
    check("wrap_zero", 32'(bus_a.O_PIXEL_COUNT), 32'h0000);
    send_pixel(8'h03, 1'b1);
    wait_idle();
    check("wrap_restart", 32'(bus_a.O_PIXEL_COUNT), 32'd1);

    // Reset in SEND_1 with the skid buffer full discards both pixels.
    send_pixel(8'h11, 1'b0);
    send_pixel(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_chan", 32'(bus_a.O_BYTE_CHANNEL), 32'd1);
    check("rst_mid_ready", 32'(bus_a.O_PIXEL_READY), 32'd0);
    @(posedge clk); #1;
    q_a.delete(); q_b.delete();
    model_cnt = 16'd0;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus_a.O_BYTE_VALID), 32'd0);
    check("rst_mid_count", 32'(bus_a.O_PIXEL_COUNT), 32'd0);
    check("rst_mid_byte", 32'(bus_a.O_BYTE), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", 32'(bus_a.O_PIXEL_READY), 32'd1);
    repeat (10) @(negedge clk);
    check("rst_mid_no_stale", 32'(bus_a.O_BYTE_VALID), 32'd0);
    @(posedge clk); #1;

    // Traffic after the reset resumes normally.
    send_pixel(8'hC3, 1'b1);
    wait_idle();
    check("post_rst_count", 32'(bus_a.O_PIXEL_COUNT), 32'd1);

    check("end_queue_a", 32'(q_a.size()), 32'd0);
    check("end_queue_b", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
